// File: rtl/p4_mux_sched_pkg.sv
// Shared types and helpers for the header/payload pair-mux packet scheduler.
package p4_mux_sched_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // A programmed weight of zero still earns one packet per round.
  function automatic int unsigned weight_clamp(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/p4_mux_sched_rr_select.sv
// Round-robin pick: rotate requests by the pointer, take the lowest set bit,
// rotate the index back. Purely combinational.
module p4_mux_sched_rr_select #(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned CL_S_COUNT = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0]    req_i,
  input  logic [CL_S_COUNT-1:0] ptr_i,
  output logic [S_COUNT-1:0]    grant_o,
  output logic [CL_S_COUNT-1:0] idx_o,
  output logic                  valid_o
);

  logic [S_COUNT-1:0]    rot;
  logic [CL_S_COUNT-1:0] k;
  logic [CL_S_COUNT:0]   sum;

  always_comb begin
    rot     = S_COUNT'({req_i, req_i} >> ptr_i);
    valid_o = |rot;
    k       = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (rot[i]) k = CL_S_COUNT'(i);
    end
    sum = {1'b0, ptr_i} + {1'b0, k};
    if (sum >= (CL_S_COUNT + 1)'(S_COUNT)) sum = sum - (CL_S_COUNT + 1)'(S_COUNT);
    idx_o   = sum[CL_S_COUNT-1:0];
    grant_o = valid_o ? (S_COUNT'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/p4_mux_sched.sv
// Weighted round-robin packet scheduler: grants one source and holds it until
// both header and payload tlast of the packet have gone out, with a stall watchdog.
module p4_mux_sched
  import p4_mux_sched_pkg::*;
#(
  parameter int unsigned S_COUNT       = 4,
  parameter int unsigned CL_S_COUNT    = $clog2(S_COUNT),
  parameter int unsigned WEIGHT_WIDTH  = 4,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT-1:0]              req_i,
  input  logic [S_COUNT-1:0]              cfg_enable_i,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] cfg_weight_i,
  input  logic [TIMEOUT_WIDTH-1:0]        cfg_timeout_i,
  input  logic                            hdr_beat_i,
  input  logic                            hdr_last_i,
  input  logic                            pld_beat_i,
  input  logic                            pld_last_i,
  output logic [S_COUNT-1:0]              grant_o,
  output logic [CL_S_COUNT-1:0]           grant_encoded_o,
  output logic                            grant_valid_o,
  output logic                            timeout_err_o
);

  state_e                  state_q;
  logic [S_COUNT-1:0]      grant_q;
  logic [CL_S_COUNT-1:0]   enc_q;
  logic                    valid_q;
  logic                    terr_q;
  logic [CL_S_COUNT-1:0]   ptr_q;
  logic [WEIGHT_WIDTH-1:0] credit_q [S_COUNT];
  logic                    hdr_done_q, pld_done_q;
  logic [TIMEOUT_WIDTH-1:0] wd_q;

  logic [S_COUNT-1:0]      elig_base, credit_nz, elig;
  logic                    reload;
  logic                    hdr_done_d, pld_done_d, complete, stall, wd_fire;
  logic [TIMEOUT_WIDTH-1:0] wd_d;
  logic [WEIGHT_WIDTH-1:0] dec_credit;
  logic [CL_S_COUNT-1:0]   next_ptr;
  logic [S_COUNT-1:0]      sel_grant;
  logic [CL_S_COUNT-1:0]   sel_idx;
  logic                    sel_valid;

  always_comb begin
    elig_base = req_i & cfg_enable_i;
    for (int i = 0; i < S_COUNT; i++) credit_nz[i] = (credit_q[i] != '0);
    // Everyone still asking has spent its credit: open a new round right away.
    reload = ((elig_base & credit_nz) == '0) && (elig_base != '0);
    elig   = reload ? elig_base : (elig_base & credit_nz);

    hdr_done_d = hdr_done_q | hdr_last_i;
    pld_done_d = pld_done_q | pld_last_i;
    complete   = hdr_done_d & pld_done_d;
    stall      = !(hdr_beat_i || pld_beat_i);
    wd_d       = stall ? wd_q + TIMEOUT_WIDTH'(1) : '0;
    wd_fire    = stall && (cfg_timeout_i != '0) && (wd_d == cfg_timeout_i);

    dec_credit = credit_q[enc_q] - WEIGHT_WIDTH'(1);
    next_ptr   = (enc_q == CL_S_COUNT'(S_COUNT - 1)) ? '0 : enc_q + CL_S_COUNT'(1);
  end

  p4_mux_sched_rr_select #(
    .S_COUNT    (S_COUNT),
    .CL_S_COUNT (CL_S_COUNT)
  ) u_rr_select (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .grant_o (sel_grant),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      enc_q      <= '0;
      valid_q    <= 1'b0;
      terr_q     <= 1'b0;
      ptr_q      <= '0;
      hdr_done_q <= 1'b0;
      pld_done_q <= 1'b0;
      wd_q       <= '0;
      for (int i = 0; i < S_COUNT; i++) credit_q[i] <= '0;
    end else begin
      terr_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sel_valid) begin
            if (reload) begin
              for (int i = 0; i < S_COUNT; i++) begin
                credit_q[i] <= WEIGHT_WIDTH'(weight_clamp(
                    32'(cfg_weight_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH])));
              end
            end
            grant_q <= sel_grant;
            enc_q   <= sel_idx;
            valid_q <= 1'b1;
            wd_q    <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (complete || wd_fire) begin
            // A watchdog release forfeits the rest of the source's round.
            credit_q[enc_q] <= complete ? dec_credit : '0;
            ptr_q      <= (complete && dec_credit != '0) ? enc_q : next_ptr;
            terr_q     <= !complete;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            hdr_done_q <= 1'b0;
            pld_done_q <= 1'b0;
            wd_q       <= '0;
            state_q    <= StIdle;
          end else begin
            hdr_done_q <= hdr_done_d;
            pld_done_q <= pld_done_d;
            wd_q       <= wd_d;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_o         = grant_q;
  assign grant_encoded_o = enc_q;
  assign grant_valid_o   = valid_q;
  assign timeout_err_o   = terr_q;

endmodule

// File: tb/tb_p4_mux_sched.sv
// Directed bench for p4_mux_sched: arbitration order, pair completion, watchdog,
// enable handling and mid-packet reset.
module tb_p4_mux_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, cfg_enable, grant;
  logic [15:0] cfg_weight, cfg_timeout;
  logic        hdr_beat, hdr_last, pld_beat, pld_last;
  logic [1:0]  grant_encoded;
  logic        grant_valid, timeout_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  p4_mux_sched dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req),
    .cfg_enable_i    (cfg_enable),
    .cfg_weight_i    (cfg_weight),
    .cfg_timeout_i   (cfg_timeout),
    .hdr_beat_i      (hdr_beat),
    .hdr_last_i      (hdr_last),
    .pld_beat_i      (pld_beat),
    .pld_last_i      (pld_last),
    .grant_o         (grant),
    .grant_encoded_o (grant_encoded),
    .grant_valid_o   (grant_valid),
    .timeout_err_o   (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req         = '0;
    cfg_enable  = 4'b1111;
    cfg_weight  = 16'h1111;
    cfg_timeout = '0;
    hdr_beat    = 1'b0;
    hdr_last    = 1'b0;
    pld_beat    = 1'b0;
    pld_last    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Header and payload tlast in the same cycle.
  task automatic finish_pkt();
    hdr_beat = 1'b1; hdr_last = 1'b1; pld_beat = 1'b1; pld_last = 1'b1;
    tick();
    hdr_beat = 1'b0; hdr_last = 1'b0; pld_beat = 1'b0; pld_last = 1'b0;
  endtask

  task automatic pulse_hdr_last();
    hdr_beat = 1'b1; hdr_last = 1'b1;
    tick();
    hdr_beat = 1'b0; hdr_last = 1'b0;
  endtask

  task automatic pulse_pld_last();
    pld_beat = 1'b1; pld_last = 1'b1;
    tick();
    pld_beat = 1'b0; pld_last = 1'b0;
  endtask

  initial begin
    logic [1:0] t2_exp [8];
    t2_exp = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3};

    // 1: reset values, basic grant and one idle cycle between packets
    do_reset();
    rst = 1'b1;
    tick();
    check_eq("rst grant", 32'(grant), 32'h0);
    check_eq("rst enc", 32'(grant_encoded), 32'h0);
    check_eq("rst valid", 32'(grant_valid), 32'h0);
    check_eq("rst terr", 32'(timeout_err), 32'h0);
    rst = 1'b0;
    req = 4'b0101;
    tick();
    check_eq("t1 valid0", 32'(grant_valid), 32'h1);
    check_eq("t1 grant0", 32'(grant), 32'h1);
    check_eq("t1 enc0", 32'(grant_encoded), 32'h0);
    finish_pkt();
    check_eq("t1 idle", 32'(grant_valid), 32'h0);
    tick();
    check_eq("t1 grant2", 32'(grant), 32'h4);
    check_eq("t1 enc2", 32'(grant_encoded), 32'h2);
    req = '0;
    finish_pkt();

    // 2: weight 3 on source 3
    do_reset();
    cfg_weight = {4'd3, 4'd1, 4'd1, 4'd1};
    req = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("t2 valid%0d", i), 32'(grant_valid), 32'h1);
      check_eq($sformatf("t2 enc%0d", i), 32'(grant_encoded), 32'(t2_exp[i]));
      finish_pkt();
      check_eq($sformatf("t2 idle%0d", i), 32'(grant_valid), 32'h0);
    end

    // 3: payload tlast first, lasts while idle, same-cycle lasts
    do_reset();
    req = 4'b0001;
    tick();
    check_eq("t3 grant0", 32'(grant), 32'h1);
    req = '0;
    pulse_pld_last();
    check_eq("t3 hold a", 32'(grant_valid), 32'h1);
    tick();
    check_eq("t3 hold b", 32'(grant_valid), 32'h1);
    pulse_hdr_last();
    check_eq("t3 release", 32'(grant_valid), 32'h0);
    pulse_hdr_last();
    check_eq("t3 idle last", 32'(grant_valid), 32'h0);
    req = 4'b0100;
    tick();
    check_eq("t3 enc2", 32'(grant_encoded), 32'h2);
    req = '0;
    pulse_pld_last();
    check_eq("t3 idle hdr ignored", 32'(grant_valid), 32'h1);
    pulse_hdr_last();
    check_eq("t3 release2", 32'(grant_valid), 32'h0);
    req = 4'b0010;
    tick();
    check_eq("t3 enc1", 32'(grant_encoded), 32'h1);
    req = '0;
    finish_pkt();
    check_eq("t3 same-cycle", 32'(grant_valid), 32'h0);

    // 4: watchdog release after 8 stall cycles, then rest of the round
    do_reset();
    cfg_timeout = 16'd8;
    req = 4'b0100;
    tick();
    check_eq("t4 enc2", 32'(grant_encoded), 32'h2);
    req = 4'b0111;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("t4 stall%0d", i), 32'({grant_valid, timeout_err}), 32'h2);
    end
    tick();
    check_eq("t4 released", 32'(grant_valid), 32'h0);
    check_eq("t4 terr", 32'(timeout_err), 32'h1);
    tick();
    check_eq("t4 terr pulse", 32'(timeout_err), 32'h0);
    check_eq("t4 next src0", 32'({grant_valid, grant_encoded}), 32'h4);
    finish_pkt();
    tick();
    check_eq("t4 next src1", 32'({grant_valid, grant_encoded}), 32'h5);
    finish_pkt();
    tick();
    check_eq("t4 then src2", 32'({grant_valid, grant_encoded}), 32'h6);
    req = '0;
    for (int i = 0; i < 20; i++) begin
      hdr_beat = (i % 5 == 0);
      tick();
      check_eq($sformatf("t4 beats%0d", i), 32'({grant_valid, timeout_err}), 32'h2);
    end
    hdr_beat = 1'b0;
    finish_pkt();

    // 5: disabling the granted source does not abort its packet
    do_reset();
    req = 4'b0010;
    tick();
    check_eq("t5 enc1", 32'(grant_encoded), 32'h1);
    cfg_enable = 4'b1101;
    tick();
    check_eq("t5 hold", 32'(grant_valid), 32'h1);
    finish_pkt();
    check_eq("t5 done", 32'(grant_valid), 32'h0);
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t5 grant%0d", i), 32'({grant_valid, grant}), 32'h11);
      finish_pkt();
    end
    req = '0;

    // 6: reset while busy
    do_reset();
    req = 4'b0001;
    tick();
    check_eq("t6 enc0", 32'(grant_encoded), 32'h0);
    req = 4'b0100;
    finish_pkt();
    tick();
    check_eq("t6 enc2", 32'({grant_valid, grant_encoded}), 32'h6);
    rst = 1'b1;
    tick();
    check_eq("t6 rst grant", 32'(grant), 32'h0);
    check_eq("t6 rst enc", 32'(grant_encoded), 32'h0);
    check_eq("t6 rst valid", 32'(grant_valid), 32'h0);
    check_eq("t6 rst terr", 32'(timeout_err), 32'h0);
    rst = 1'b0;
    req = 4'b0101;
    tick();
    check_eq("t6 ptr restart", 32'({grant_valid, grant_encoded}), 32'h4);
    req = '0;
    finish_pkt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
